// File: rtl/sparse_boundary_matrix_builder.sv
// Streaming CSC encoder: sorted (row, value) beats in, entry and column-pointer writes out.
// Optional build macro SPARSE_ZERO_FILTER_EN drops zero-valued entry beats instead of storing them.
module sparse_boundary_matrix_builder #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 12,
  parameter int MAX_ENTRIES   = 4096,
  parameter int CSC_PTR_WIDTH = 16,
  parameter int COL_WIDTH     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [COL_WIDTH-1:0]     num_cols,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_WIDTH-1:0]    in_row,
  input  logic [DATA_WIDTH-1:0]    in_value,
  input  logic                     in_last,
  input  logic                     in_empty,
  output logic                     ent_wr_en,
  output logic [ADDR_WIDTH-1:0]    ent_wr_addr,
  output logic [DATA_WIDTH-1:0]    ent_wr_value,
  output logic [ADDR_WIDTH-1:0]    ent_wr_row,
  output logic                     ptr_wr_en,
  output logic [COL_WIDTH-1:0]     ptr_wr_addr,
  output logic [CSC_PTR_WIDTH-1:0] ptr_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [CSC_PTR_WIDTH-1:0] nnz_count,
  output logic                     err_overflow,
  output logic                     err_order
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_ERROR} state_t;

  state_t                   state;
  logic [COL_WIDTH-1:0]     col;
  logic [COL_WIDTH-1:0]     cols_q;
  logic [CSC_PTR_WIDTH-1:0] nnz;
  logic [ADDR_WIDTH-1:0]    prev_row;
  logic                     col_has_entry;

  logic                     accept;
  logic                     is_entry;
  logic                     ovf_hit;
  logic                     ord_hit;
  logic                     last_col;
  logic [CSC_PTR_WIDTH-1:0] nnz_next;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    accept   = in_valid && (state == S_FILL);
`ifdef SPARSE_ZERO_FILTER_EN
    is_entry = !in_empty && (in_value != '0);
`else
    is_entry = !in_empty;
`endif
    ovf_hit  = accept && is_entry && (nnz == CSC_PTR_WIDTH'(MAX_ENTRIES));
    ord_hit  = accept && is_entry && col_has_entry && (in_row <= prev_row);
    last_col = (col == cols_q - 1'b1);
    nnz_next = nnz + CSC_PTR_WIDTH'(is_entry);
  end

  assign in_ready  = (state == S_FILL);
  assign busy      = (state == S_FILL);
  assign nnz_count = nnz;

  // NOTE: sequential state uses non-blocking assignments only; all control and output
  // registers are reset, while the data-only write fields are reset too so outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      col           <= '0;
      cols_q        <= '0;
      nnz           <= '0;
      prev_row      <= '0;
      col_has_entry <= 1'b0;
      ent_wr_en     <= 1'b0;
      ent_wr_addr   <= '0;
      ent_wr_value  <= '0;
      ent_wr_row    <= '0;
      ptr_wr_en     <= 1'b0;
      ptr_wr_addr   <= '0;
      ptr_wr_data   <= '0;
      done          <= 1'b0;
      err_overflow  <= 1'b0;
      err_order     <= 1'b0;
    end else begin
      ent_wr_en <= 1'b0;
      ptr_wr_en <= 1'b0;
      done      <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else if (start && (state != S_FILL)) begin
        nnz           <= '0;
        col           <= '0;
        cols_q        <= num_cols;
        col_has_entry <= 1'b0;
        err_overflow  <= 1'b0;
        err_order     <= 1'b0;
        ptr_wr_en     <= 1'b1;
        ptr_wr_addr   <= '0;
        ptr_wr_data   <= '0;
        if (num_cols == '0) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else begin
          state <= S_FILL;
        end
      end else if (accept) begin
        if (ovf_hit || ord_hit) begin
          // Faulting beat is dropped entirely, including any column close it carried.
          err_overflow <= err_overflow | ovf_hit;
          err_order    <= err_order | ord_hit;
          state        <= S_ERROR;
        end else begin
          if (is_entry) begin
            ent_wr_en     <= 1'b1;
            ent_wr_addr   <= nnz[ADDR_WIDTH-1:0];
            ent_wr_value  <= in_value;
            ent_wr_row    <= in_row;
            nnz           <= nnz_next;
            prev_row      <= in_row;
            col_has_entry <= 1'b1;
          end
          if (in_last) begin
            ptr_wr_en     <= 1'b1;
            ptr_wr_addr   <= col + 1'b1;
            ptr_wr_data   <= nnz_next;
            col           <= col + 1'b1;
            col_has_entry <= 1'b0;
            if (last_col) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_boundary_matrix_builder.sv
// Self-checking bench for sparse_boundary_matrix_builder: directed vector table, corner
// sequences, and randomized matrices compared against a queue-based reference model.
module tb_sparse_boundary_matrix_builder;

  localparam int DW   = 16;
  localparam int AW   = 12;
  localparam int PW   = 16;
  localparam int CW   = 4;
  localparam int MAXE = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] num_cols = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_row = '0;
  logic [DW-1:0] in_value = '0;
  logic          in_last = 1'b0;
  logic          in_empty = 1'b0;
  logic          ent_wr_en;
  logic [AW-1:0] ent_wr_addr;
  logic [DW-1:0] ent_wr_value;
  logic [AW-1:0] ent_wr_row;
  logic          ptr_wr_en;
  logic [CW-1:0] ptr_wr_addr;
  logic [PW-1:0] ptr_wr_data;
  logic          busy;
  logic          done;
  logic [PW-1:0] nnz_count;
  logic          err_overflow;
  logic          err_order;

  sparse_boundary_matrix_builder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_ENTRIES(MAXE),
    .CSC_PTR_WIDTH(PW), .COL_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_cols(num_cols),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_value(in_value),
    .in_last(in_last), .in_empty(in_empty),
    .ent_wr_en(ent_wr_en), .ent_wr_addr(ent_wr_addr), .ent_wr_value(ent_wr_value),
    .ent_wr_row(ent_wr_row), .ptr_wr_en(ptr_wr_en), .ptr_wr_addr(ptr_wr_addr),
    .ptr_wr_data(ptr_wr_data), .busy(busy), .done(done), .nnz_count(nnz_count),
    .err_overflow(err_overflow), .err_order(err_order)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] row; logic [DW-1:0] value; logic last; logic empty; } beat_t;
  typedef struct { logic [AW-1:0] addr; logic [AW-1:0] row; logic [DW-1:0] value; } ent_t;
  typedef struct { logic [CW-1:0] addr; logic [PW-1:0] data; } ptr_t;
  typedef struct {
    logic [AW-1:0] row; logic [DW-1:0] value; logic last; logic empty;
    logic e_en; logic [AW-1:0] e_addr; logic p_en; logic [CW-1:0] p_addr; logic [PW-1:0] p_data;
    logic done_x; logic ready_x;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  beat_t beats[$];
  ent_t  got_e[$], exp_e[$];
  ptr_t  got_p[$], exp_p[$];

`ifdef SPARSE_ZERO_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Write log sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ent_wr_en) got_e.push_back('{ent_wr_addr, ent_wr_row, ent_wr_value});
      if (ptr_wr_en) got_p.push_back('{ptr_wr_addr, ptr_wr_data});
      if (done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference: CSC layout derived directly from the beat list.
  task automatic model(input int n, output int consumed, output bit e_ov, output bit e_ord,
                       output bit fin, output int nnz);
    int col;
    logic [AW-1:0] col_rows[$];
    bit entry;
    exp_e.delete(); exp_p.delete();
    consumed = 0; e_ov = 0; e_ord = 0; fin = 0; nnz = 0; col = 0;
    exp_p.push_back('{'0, '0});
    if (n == 0) begin fin = 1; return; end
    foreach (beats[i]) begin
      consumed = i + 1;
      entry = !beats[i].empty && !(ZF && beats[i].value == 0);
      if (entry) begin
        e_ov  = (nnz == MAXE);
        e_ord = (col_rows.size() > 0) && (beats[i].row <= col_rows[$]);
        if (e_ov || e_ord) return;
        exp_e.push_back('{AW'(nnz), beats[i].row, beats[i].value});
        nnz++;
        col_rows.push_back(beats[i].row);
      end
      if (beats[i].last) begin
        col++;
        exp_p.push_back('{CW'(col), PW'(nnz)});
        col_rows.delete();
        if (col == n) begin fin = 1; return; end
      end
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_cols = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input beat_t b);
    in_valid = 1'b1; in_row = b.row; in_value = b.value; in_last = b.last; in_empty = b.empty;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_matrix(input int n);
    int consumed, nnz;
    bit e_ov, e_ord, fin;
    model(n, consumed, e_ov, e_ord, fin, nnz);
    got_e.delete(); got_p.delete(); done_cnt = 0;
    do_start(n);
    for (int i = 0; i < consumed; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_row = AW'($urandom); @(negedge clk);
      end
      check("ready_before_beat", in_ready, 1);
      send(beats[i]);
    end
    @(negedge clk);
    @(negedge clk);
    check("ent_count", got_e.size(), exp_e.size());
    foreach (exp_e[i]) if (i < got_e.size()) begin
      check("ent_addr", got_e[i].addr, exp_e[i].addr);
      check("ent_row", got_e[i].row, exp_e[i].row);
      check("ent_value", got_e[i].value, exp_e[i].value);
    end
    check("ptr_count", got_p.size(), exp_p.size());
    foreach (exp_p[i]) if (i < got_p.size()) begin
      check("ptr_addr", got_p[i].addr, exp_p[i].addr);
      check("ptr_data", got_p[i].data, exp_p[i].data);
    end
    check("done_pulses", done_cnt, fin ? 1 : 0);
    check("err_overflow", err_overflow, e_ov);
    check("err_order", err_order, e_ord);
    check("nnz_count", nnz_count, nnz);
    check("ready_after", in_ready, 0);
  endtask

  task automatic gen(input int n);
    int k;
    logic [AW-1:0] row;
    beats.delete();
    for (int c = 0; c < n; c++) begin
      k = $urandom_range(0, 3);
      row = AW'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) beats.push_back('{AW'($urandom), DW'($urandom), 1'b0, 1'b1});
      if (k == 0) beats.push_back('{'0, '0, 1'b1, 1'b1});
      for (int j = 0; j < k; j++) begin
        if (j > 0 && $urandom_range(0, 15) != 0) row = row + AW'($urandom_range(1, 5));
        beats.push_back('{row, ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom), j == k - 1, 1'b0});
      end
    end
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{12'd1, 16'd5, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1};
    tbl[1] = '{12'd4, 16'd7, 1'b1, 1'b0, 1'b1, 12'd1, 1'b1, 4'd1, 16'd2, 1'b0, 1'b1};
    tbl[2] = '{12'd0, 16'd0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b1, 4'd2, 16'd2, 1'b0, 1'b1};
    tbl[3] = '{12'd0, 16'd2, 1'b0, 1'b0, 1'b1, 12'd2, 1'b0, 4'd0, 16'd0, 1'b0, 1'b1};
    tbl[4] = '{12'd2, 16'd3, 1'b1, 1'b0, 1'b1, 12'd3, 1'b1, 4'd3, 16'd4, 1'b1, 1'b0};

    // Reset state
    #3;
    check("rst_ent_en", ent_wr_en, 0);
    check("rst_ptr_en", ptr_wr_en, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_nnz", nnz_count, 0);
    check("rst_errs", {err_overflow, err_order}, 0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Directed vector table: three columns, middle one empty
    do_start(3);
    check("t_ptr0_en", ptr_wr_en, 1);
    check("t_ptr0", {ptr_wr_addr, ptr_wr_data}, 0);
    check("t_busy", busy, 1);
    foreach (tbl[i]) begin
      in_valid = 1'b1; in_row = tbl[i].row; in_value = tbl[i].value;
      in_last = tbl[i].last; in_empty = tbl[i].empty;
      @(negedge clk);
      in_valid = 1'b0;
      check("t_ent_en", ent_wr_en, tbl[i].e_en);
      if (tbl[i].e_en) begin
        check("t_ent_addr", ent_wr_addr, tbl[i].e_addr);
        check("t_ent_row", ent_wr_row, tbl[i].row);
        check("t_ent_value", ent_wr_value, tbl[i].value);
      end
      check("t_ptr_en", ptr_wr_en, tbl[i].p_en);
      if (tbl[i].p_en) begin
        check("t_ptr_addr", ptr_wr_addr, tbl[i].p_addr);
        check("t_ptr_data", ptr_wr_data, tbl[i].p_data);
      end
      check("t_done", done, tbl[i].done_x);
      check("t_ready", in_ready, tbl[i].ready_x);
    end
    check("t_nnz", nnz_count, 4);
    @(negedge clk);
    check("t_done_single", done, 0);
    check("t_nnz_hold", nnz_count, 4);

    // Zero columns: sentinel only, done next cycle, never ready
    do_start(0);
    check("z_ptr", {ptr_wr_en, ptr_wr_addr, ptr_wr_data}, {1'b1, 4'd0, 16'd0});
    check("z_done", done, 1);
    check("z_ready", in_ready, 0);
    @(negedge clk);
    check("z_ready2", in_ready, 0);
    check("z_done2", done, 0);

    // Overflow: one column of MAXE+1 entries
    beats.delete();
    for (int i = 0; i <= MAXE; i++) beats.push_back('{AW'(i), DW'(i + 1), i == MAXE, 1'b0});
    run_matrix(1);
    check("ovf_writes", got_e.size(), MAXE);
    check("ovf_flag", err_overflow, 1);
    check("ovf_busy", busy, 0);

    // Order error, then restart clears it
    beats.delete();
    beats.push_back('{12'd3, 16'd1, 1'b0, 1'b0});
    beats.push_back('{12'd3, 16'd2, 1'b1, 1'b0});
    run_matrix(2);
    check("ord_writes", got_e.size(), 1);
    check("ord_flag", err_order, 1);
    do_start(1);
    check("ord_cleared", {err_order, err_overflow}, 0);
    check("ord_restart_busy", busy, 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    // Zero-valued entry mid-column
    beats.delete();
    beats.push_back('{12'd1, 16'd9, 1'b0, 1'b0});
    beats.push_back('{12'd2, 16'd0, 1'b0, 1'b0});
    beats.push_back('{12'd5, 16'd4, 1'b1, 1'b0});
    run_matrix(1);
    if (got_p.size() > 1) check("zero_ptr1", got_p[1].data, ZF ? 2 : 3);
    else check("zero_ptr_missing", got_p.size(), 2);

    // Largest column count: sentinel lands at the last table slot
    beats.delete();
    for (int i = 0; i < 15; i++) beats.push_back('{'0, '0, 1'b1, 1'b1});
    run_matrix(15);
    if (got_p.size() == 16) check("sent_addr", got_p[15].addr, 15);
    else check("sent_count", got_p.size(), 16);

    // Abort mid-matrix suppresses the pending beat; abort beats a simultaneous start
    do_start(2);
    in_valid = 1'b1; in_row = 12'd1; in_value = 16'd1; in_last = 1'b0; in_empty = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_no_write", {ent_wr_en, ptr_wr_en}, 0);
    check("abort_idle", {in_ready, busy}, 0);
    start = 1'b1; abort = 1'b1; num_cols = 4'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_over_start", {busy, ptr_wr_en}, 0);

    // Async reset after two of three columns
    do_start(3);
    send('{12'd1, 16'd3, 1'b1, 1'b0});
    send('{12'd2, 16'd4, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check("ar_outputs", {ent_wr_en, ptr_wr_en, ptr_wr_addr, ptr_wr_data, busy, done, in_ready}, 0);
    check("ar_nnz_errs", {nnz_count, err_overflow, err_order}, 0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    do_start(3);
    check("ar_restart_ptr", {ptr_wr_en, ptr_wr_addr, ptr_wr_data}, {1'b1, 4'd0, 16'd0});
    check("ar_restart_nnz", nnz_count, 0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;

    // Randomized matrices against the reference model
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(0, 6);
      gen(n);
      run_matrix(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
